// File: rtl/fg_request_scanner.sv
// Raster read-request generator for the SRAM foreground read port.
// Issues tagged x/y reads at a programmed rate and pairs returned pixels with their tags.
module fg_request_scanner #(
  parameter int H_TOTAL         = 1056,
  parameter int V_TOTAL         = 628,
  parameter int COORD_W         = 11,
  parameter int DATA_W          = 16,
  parameter int REQ_PERIOD      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 oneshot,
  output logic                                 request_active,
  output logic [COORD_W-1:0]                   request_x,
  output logic [COORD_W-1:0]                   request_y,
  input  logic                                 request_ready,
  input  logic [DATA_W-1:0]                    request_data,
  output logic                                 out_write,
  output logic [2*COORD_W+DATA_W-1:0]          out_data,
  input  logic                                 out_full,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 frame_done,
  output logic                                 busy,
  output logic                                 err_spurious
);
  localparam int OUT_W = 2*COORD_W + DATA_W;
  localparam int TAG_W = 2*COORD_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int DIV_W = (REQ_PERIOD > 1) ? $clog2(REQ_PERIOD) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REQ_PERIOD-1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING-1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 oneshot_q, oneshot_d;
  logic [TAG_W-1:0]     tag_mem_q [MAX_OUTSTANDING];
  logic [TAG_W-1:0]     tag_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 request_active_q, request_active_d;
  logic [COORD_W-1:0]   request_x_q, request_x_d, request_y_q, request_y_d;
  logic                 frame_done_q, frame_done_d;
  logic                 out_write_q, out_write_d;
  logic [OUT_W-1:0]     out_data_q, out_data_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic issue, last_x, last_y, push, pop, bypass;
  logic [TAG_W-1:0] head_tag;

  always_comb begin
    last_x   = (x_q == COORD_W'(H_TOTAL-1));
    last_y   = (y_q == COORD_W'(V_TOTAL-1));
    issue    = (state_q == SCAN) && (div_q == DIV_LAST) &&
               (cnt_q < CNT_W'(MAX_OUTSTANDING)) && !out_full;
    // A response arriving with an empty FIFO in the issuing cycle takes the tag being issued.
    bypass   = issue && request_ready && (cnt_q == '0);
    pop      = request_ready && (cnt_q != '0);
    push     = issue && !bypass;
    head_tag = bypass ? {x_q, y_q} : tag_mem_q[rd_ptr_q];

    state_d          = state_q;
    x_d              = x_q;
    y_d              = y_q;
    div_d            = div_q;
    oneshot_d        = oneshot_q;
    tag_mem_d        = tag_mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    cnt_d            = cnt_q;
    request_active_d = issue;
    request_x_d      = issue ? x_q : request_x_q;
    request_y_d      = issue ? y_q : request_y_q;
    frame_done_d     = issue && last_x && last_y;
    out_write_d      = pop || bypass;
    out_data_d       = (pop || bypass) ? {head_tag, request_data} : out_data_q;
    err_d            = err_q || (request_ready && (cnt_q == '0) && !issue);

    if (push) begin
      tag_mem_d[wr_ptr_q] = {x_q, y_q};
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: if (enable) begin
        state_d   = SCAN;
        oneshot_d = oneshot;
        x_d       = '0;
        y_d       = '0;
        div_d     = '0;
      end
      SCAN: begin
        if (div_q != DIV_LAST) div_d = div_q + 1'b1;
        else if (issue)        div_d = '0;
        if (issue) begin
          if (last_x) begin
            x_d = '0;
            y_d = last_y ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
        if (!enable || (oneshot_q && issue && last_x && last_y)) begin
          state_d = DRAIN;
          div_d   = '0;
        end
      end
      DRAIN: if (cnt_q == '0) begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      x_q              <= '0;
      y_q              <= '0;
      div_q            <= '0;
      oneshot_q        <= 1'b0;
      tag_mem_q        <= '{default: '0};
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      request_active_q <= 1'b0;
      request_x_q      <= '0;
      request_y_q      <= '0;
      frame_done_q     <= 1'b0;
      out_write_q      <= 1'b0;
      out_data_q       <= '0;
      busy_q           <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      x_q              <= x_d;
      y_q              <= y_d;
      div_q            <= div_d;
      oneshot_q        <= oneshot_d;
      tag_mem_q        <= tag_mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      request_active_q <= request_active_d;
      request_x_q      <= request_x_d;
      request_y_q      <= request_y_d;
      frame_done_q     <= frame_done_d;
      out_write_q      <= out_write_d;
      out_data_q       <= out_data_d;
      busy_q           <= busy_d;
      err_q            <= err_d;
    end
  end

  assign request_active = request_active_q;
  assign request_x      = request_x_q;
  assign request_y      = request_y_q;
  assign frame_done     = frame_done_q;
  assign out_write      = out_write_q;
  assign out_data       = out_data_q;
  assign outstanding    = cnt_q;
  assign busy           = busy_q;
  assign err_spurious   = err_q;
endmodule

// File: tb/tb_fg_request_scanner.sv
// Scoreboard bench for fg_request_scanner: default-size instance (a) and small-raster instance (b).
module tb_fg_request_scanner;
  localparam int CW = 11;
  localparam int DW = 16;
  localparam int OW = 2*CW + DW;

  typedef struct {logic [CW-1:0] x; logic [CW-1:0] y; logic fd; int cyc;} req_t;
  typedef struct {logic [OW-1:0] d; int cyc;} out_t;
  typedef struct {logic [CW-1:0] x; logic [CW-1:0] y; int due;} pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  logic          enable_a = 0, oneshot_a = 0, rdy_a, full_a = 0;
  logic [DW-1:0] rdata_a;
  logic          req_a, wr_a, fd_a, busy_a, err_a;
  logic [CW-1:0] rx_a, ry_a;
  logic [OW-1:0] odata_a;
  logic [2:0]    outst_a;

  logic          enable_b = 0, oneshot_b = 0, rdy_b, full_b = 0;
  logic [DW-1:0] rdata_b;
  logic          req_b, wr_b, fd_b, busy_b, err_b;
  logic [CW-1:0] rx_b, ry_b;
  logic [OW-1:0] odata_b;
  logic [2:0]    outst_b;

  fg_request_scanner u_a (
    .clk(clk), .rst(rst), .enable(enable_a), .oneshot(oneshot_a),
    .request_active(req_a), .request_x(rx_a), .request_y(ry_a),
    .request_ready(rdy_a), .request_data(rdata_a),
    .out_write(wr_a), .out_data(odata_a), .out_full(full_a),
    .outstanding(outst_a), .frame_done(fd_a), .busy(busy_a), .err_spurious(err_a));

  fg_request_scanner #(.H_TOTAL(8), .V_TOTAL(4), .REQ_PERIOD(1)) u_b (
    .clk(clk), .rst(rst), .enable(enable_b), .oneshot(oneshot_b),
    .request_active(req_b), .request_x(rx_b), .request_y(ry_b),
    .request_ready(rdy_b), .request_data(rdata_b),
    .out_write(wr_b), .out_data(odata_b), .out_full(full_b),
    .outstanding(outst_b), .frame_done(fd_b), .busy(busy_b), .err_spurious(err_b));

  req_t  exq_req_a[$], exq_req_b[$];
  out_t  exq_out_a[$], exq_out_b[$];
  pend_t pend_a[$], pend_b[$];
  int n_tests = 0, n_fail = 0;
  int lat_a = 2, lat_b = 0, credit_a = 0;
  bit hold_a = 0, spur_b = 0;

  function automatic logic [DW-1:0] pix(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return {x[7:0] ^ 8'h5A, y[7:0] ^ 8'hC3};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, pcyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, expected none (cycle %0d)", nm, pcyc);
  endtask

  task automatic wait_until(input int c);
    while (pcyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input bit sel, input string nm);
    for (int i = 0; i < 300 && (sel ? busy_b : busy_a); i++) begin
      @(posedge clk);
      #1;
    end
    check(nm, sel ? busy_b : busy_a, 0);
  endtask

  task automatic exp_a(input int x, input int y, input int rcyc, input int ocyc);
    exq_req_a.push_back(req_t'{CW'(x), CW'(y), 1'b0, rcyc});
    exq_out_a.push_back(out_t'{{CW'(x), CW'(y), pix(CW'(x), CW'(y))}, ocyc});
  endtask

  task automatic exp_b(input int x, input int y, input bit fd, input int rcyc, input int ocyc);
    exq_req_b.push_back(req_t'{CW'(x), CW'(y), fd, rcyc});
    exq_out_b.push_back(out_t'{{CW'(x), CW'(y), pix(CW'(x), CW'(y))}, ocyc});
  endtask

  // monitors: pop expected entries whenever the DUT presents a request or an output word
  initial begin
    req_t r;
    out_t o;
    forever begin
      @(negedge clk);
      if (!rst && req_a) begin
        if (exq_req_a.size() == 0) unexpected("a_request");
        else begin
          r = exq_req_a.pop_front();
          check("a_req_xy", {rx_a, ry_a}, {r.x, r.y});
          check("a_req_frame_done", fd_a, r.fd);
          if (r.cyc >= 0) check("a_req_cycle", pcyc, r.cyc);
        end
      end
      if (!rst && wr_a) begin
        if (exq_out_a.size() == 0) unexpected("a_out_write");
        else begin
          o = exq_out_a.pop_front();
          check("a_out_data", odata_a, o.d);
          if (o.cyc >= 0) check("a_out_cycle", pcyc, o.cyc);
        end
      end
    end
  end

  initial begin
    req_t r;
    out_t o;
    forever begin
      @(negedge clk);
      if (!rst && req_b) begin
        if (exq_req_b.size() == 0) unexpected("b_request");
        else begin
          r = exq_req_b.pop_front();
          check("b_req_xy", {rx_b, ry_b}, {r.x, r.y});
          check("b_req_frame_done", fd_b, r.fd);
          if (r.cyc >= 0) check("b_req_cycle", pcyc, r.cyc);
        end
      end
      if (!rst && wr_b) begin
        if (exq_out_b.size() == 0) unexpected("b_out_write");
        else begin
          o = exq_out_b.pop_front();
          check("b_out_data", odata_b, o.d);
          if (o.cyc >= 0) check("b_out_cycle", pcyc, o.cyc);
        end
      end
    end
  end

  // SRAM models: answer each request lat cycles later, in order
  initial begin
    rdy_a = 0;
    rdata_a = '0;
    forever begin
      @(negedge clk);
      rdy_a = 0;
      if (rst) pend_a.delete();
      else begin
        if (req_a) pend_a.push_back(pend_t'{rx_a, ry_a, pcyc + lat_a});
        if (pend_a.size() > 0 && pend_a[0].due <= pcyc && (!hold_a || credit_a > 0)) begin
          rdy_a = 1;
          rdata_a = pix(pend_a[0].x, pend_a[0].y);
          void'(pend_a.pop_front());
          if (hold_a) credit_a--;
        end
      end
    end
  end

  initial begin
    rdy_b = 0;
    rdata_b = '0;
    forever begin
      @(negedge clk);
      rdy_b = spur_b;
      rdata_b = 16'hDEAD;
      if (rst) pend_b.delete();
      else begin
        if (req_b) pend_b.push_back(pend_t'{rx_b, ry_b, pcyc + lat_b});
        if (pend_b.size() > 0 && pend_b[0].due <= pcyc) begin
          rdy_b = 1;
          rdata_b = pix(pend_b[0].x, pend_b[0].y);
          void'(pend_b.pop_front());
        end
      end
    end
  end

  task automatic check_empty(input string nm);
    check({nm, "_req_left_a"}, exq_req_a.size(), 0);
    check({nm, "_out_left_a"}, exq_out_a.size(), 0);
    check({nm, "_req_left_b"}, exq_req_b.size(), 0);
    check({nm, "_out_left_b"}, exq_out_b.size(), 0);
  endtask

  initial begin
    int k;
    #2;
    check("rst_req_active", req_a, 0);
    check("rst_out_write", wr_a, 0);
    check("rst_outstanding", outst_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_frame_done", fd_a, 0);
    check("rst_out_data_b", odata_b, 0);
    @(posedge clk);
    #1;
    rst = 0;
    wait_until(3);

    // basic timing, default parameters, response 2 clk after request
    k = pcyc;
    for (int i = 0; i < 3; i++) exp_a(i, 0, k + 5 + 4*i, k + 8 + 4*i);
    enable_a = 1;
    wait_until(k + 14);
    enable_a = 0;
    wait_idle(0, "t1_idle");
    check("t1_outstanding", outst_a, 0);
    check_empty("t1");

    // small raster, zero-latency echo, continuous across the frame boundary
    k = pcyc;
    lat_b = 0;
    for (int n = 1; n <= 41; n++)
      exp_b((n-1) % 8, ((n-1) / 8) % 4, ((n-1) % 32) == 31, k + 1 + n, k + 2 + n);
    enable_b = 1;
    wait_until(k + 41);
    enable_b = 0;
    wait_idle(1, "t2_idle");
    check_empty("t2");

    // outstanding limit with responses withheld
    k = pcyc;
    hold_a = 1;
    credit_a = 0;
    exp_a(0, 0, k + 5, k + 31);
    for (int i = 1; i < 4; i++) exp_a(i, 0, k + 5 + 4*i, -1);
    exp_a(4, 0, k + 32, -1);
    enable_a = 1;
    wait_until(k + 30);
    check("t3_outstanding_full", outst_a, 4);
    credit_a = 1;
    wait_until(k + 45);
    check("t3_outstanding_refill", outst_a, 4);
    hold_a = 0;
    enable_a = 0;
    wait_idle(0, "t3_idle");
    check_empty("t3");

    // out_full blocks issues but not responses
    k = pcyc;
    lat_a = 2;
    exp_a(0, 0, k + 5, k + 8);
    exp_a(1, 0, k + 21, k + 24);
    enable_a = 1;
    wait_until(k + 7);
    full_a = 1;
    wait_until(k + 20);
    check("t4_drained_while_full", outst_a, 0);
    full_a = 0;
    wait_until(k + 22);
    enable_a = 0;
    wait_idle(0, "t4_idle");
    check_empty("t4");

    // single frame, then stop
    lat_b = 2;
    for (int n = 1; n <= 32; n++) exp_b((n-1) % 8, (n-1) / 8, n == 32, -1, -1);
    oneshot_b = 1;
    enable_b = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fd_b) break;
    end
    check("t5_frame_done", fd_b, 1);
    enable_b = 0;
    oneshot_b = 0;
    check("t5_busy_drain", busy_b, 1);
    wait_idle(1, "t5_idle");
    check("t5_outstanding", outst_b, 0);
    check_empty("t5");

    // spurious response in IDLE
    check("t5_err_before", err_b, 0);
    @(posedge clk);
    #1;
    spur_b = 1;
    @(posedge clk);
    #1;
    spur_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_err_sticky", err_b, 1);
    check("t5_busy_after_spur", busy_b, 0);

    // asynchronous reset with three requests in flight
    k = pcyc;
    hold_a = 1;
    credit_a = 0;
    for (int i = 0; i < 3; i++) exp_a(i, 0, k + 5 + 4*i, -1);
    enable_a = 1;
    wait_until(k + 15);
    check("t6_outstanding_pre", outst_a, 3);
    check("t6_busy_pre", busy_a, 1);
    rst = 1;
    #1;
    check("t6_outstanding_rst", outst_a, 0);
    check("t6_busy_rst", busy_a, 0);
    check("t6_req_rst", req_a, 0);
    check("t6_wr_rst", wr_a, 0);
    check("t6_out_data_rst", odata_a, 0);
    check("t6_err_b_rst", err_b, 0);
    exq_out_a.delete();
    enable_a = 0;
    hold_a = 0;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_outstanding_after", outst_a, 0);
    check_empty("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
